// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART TX arbiter
package uart_arb_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int BYTE_W        = 8;
  localparam int WDOG_CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_START,
    WAIT_END,
    HOLD
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting at a priority pointer
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             any
);

  logic          found;
  logic [IW-1:0] idx;

  // Scan ptr, ptr+1, ... wrapping; the first requester seen wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = |req;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IW'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        win_idx     = idx;
        win_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one UART TX (optional UART_ARB_WDOG_EN watchdog)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEFAULT,
  parameter int WDOG_CYCLES = 16,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    uart_dv,
  output logic [BYTE_W-1:0]       uart_byte,
  input  logic                    uart_active
`ifdef UART_ARB_WDOG_EN
  ,
  output logic                    wdog_err
`endif
);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ must be 2..8");
  end
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > (1 << WDOG_CNT_W)) begin : g_bad_wdog
    $error("uart_tx_arbiter: WDOG_CYCLES does not fit the watchdog counter");
  end

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              last_q, last_d;
`ifdef UART_ARB_WDOG_EN
  logic [WDOG_CNT_W-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
`endif

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [IW-1:0]    ptr_next;
  logic             frame_done;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Priority moves to the requester just after the one that finished.
  assign ptr_next = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

  // Next-state, capture and handshake logic for the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    byte_d     = byte_q;
    last_d     = last_q;
    req_ready  = '0;
    frame_done = 1'b0;
`ifdef UART_ARB_WDOG_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        // The serializer survives our reset, so wait for it to go quiet.
        if (!uart_active && pick_any) begin
          req_ready = pick_oh;
          byte_d    = req_data[{pick_idx, 3'b000} +: BYTE_W];
          last_d    = req_last[pick_idx];
          owner_d   = pick_idx;
          grant_d   = pick_oh;
          state_d   = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_START;
`ifdef UART_ARB_WDOG_EN
        cnt_d   = '0;
`endif
      end
      WAIT_START: begin
        if (uart_active) begin
          state_d = WAIT_END;
        end
`ifdef UART_ARB_WDOG_EN
        else if (cnt_q == WDOG_CNT_W'(WDOG_CYCLES - 1)) begin
          // Serializer never started: drop the byte and carry on.
          err_d      = 1'b1;
          frame_done = 1'b1;
        end else begin
          cnt_d = cnt_q + WDOG_CNT_W'(1);
        end
`endif
      end
      WAIT_END: begin
        if (!uart_active) begin
          frame_done = 1'b1;
        end
      end
      HOLD: begin
        req_ready = grant_q;
        if (req_valid[owner_q]) begin
          byte_d  = req_data[{owner_q, 3'b000} +: BYTE_W];
          last_d  = req_last[owner_q];
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_done) begin
      if (last_q) begin
        grant_d = '0;
        ptr_d   = ptr_next;
        state_d = IDLE;
      end else begin
        state_d = HOLD;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
`ifdef UART_ARB_WDOG_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
`ifdef UART_ARB_WDOG_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign uart_dv   = (state_q == SEND);
  assign uart_byte = byte_q;
`ifdef UART_ARB_WDOG_EN
  assign wdog_err  = err_q;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_TX serializer between N_REQ byte-stream requesters (e.g. Booth result formatter, status reporter, debug echo).
- Round-robin arbitration at packet granularity: the owner keeps the UART until its byte flagged LAST completes.
- Drives the UART's DV/byte inputs. Tracks frame completion from the UART's active flag.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WDOG_CYCLES, 16, cycles allowed for UART_ACTIVE to rise after UART_DV. Used only with UART_ARB_WDOG_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- REQ_VALID  in  N_REQ  per-requester byte valid.
- REQ_LAST  in  N_REQ  byte is the last of its packet.
- REQ_DATA  in  8*N_REQ  requester i uses bits [8i+7:8i].
- REQ_READY  out  N_REQ  byte accepted when VALID & READY.
- GRANT  out  N_REQ  one-hot current owner; all-zero when free.
- BUSY  out  1  high whenever the state is not IDLE.
- UART_DV  out  1  one-cycle start strobe to the serializer.
- UART_BYTE  out  8  byte to transmit, held stable from DV until the frame ends.
- UART_ACTIVE  in  1  serializer frame-in-progress flag.
- WDOG_ERR  out  1  present only with UART_ARB_WDOG_EN.

Behaviour:
- Reset values: state IDLE, GRANT=0, REQ_READY=0, BUSY=0, UART_DV=0, UART_BYTE=0, priority pointer PTR=0, WDOG_ERR=0.
- Reset mid-frame aborts the packet. The serializer is not reset by this block, so IDLE does not arbitrate until UART_ACTIVE=0.
- States: IDLE, SEND, WAIT_START, WAIT_END, HOLD.
- IDLE:
  - If UART_ACTIVE=0 and any REQ_VALID, pick winner w: first set bit scanning PTR, PTR+1, ... wrapping mod N_REQ.
  - REQ_READY[w]=1 combinationally in the same cycle.
  - On accept: UART_BYTE<=REQ_DATA[w], last_q<=REQ_LAST[w], GRANT<=onehot(w), go to SEND.
- SEND: UART_DV=1 for exactly this cycle; go to WAIT_START. Accept at cycle t gives DV at t+1.
- WAIT_START: wait for UART_ACTIVE=1, then go to WAIT_END.
- WAIT_END:
  - Frame completion is the UART_ACTIVE 1->0 transition. The serializer's done output is not used.
  - On ACTIVE=0: if last_q, then GRANT<=0, PTR<=(w+1) mod N_REQ, go to IDLE. Otherwise go to HOLD.
- HOLD:
  - REQ_READY[owner]=1; all other READY bits stay 0.
  - On accept, capture byte and last flag, go to SEND.
  - With no valid byte, the owner waits indefinitely and GRANT is held.
- REQ_READY is never asserted outside IDLE/HOLD, and at most one bit is set at a time.
- Simultaneous requests: only the winner sees READY. Losers keep VALID and are served in rotation.
- A single-byte packet (VALID and LAST together) releases the UART after one frame.
- Data and LAST from non-owners are ignored while a packet is in progress.
- PTR advances only at packet end.

Optional Feature:
- UART_ARB_WDOG_EN defined:
  - A counter runs in WAIT_START.
  - If UART_ACTIVE is not seen within WDOG_CYCLES cycles after DV, the byte is dropped and WDOG_ERR is set; it stays set until reset.
  - The FSM then proceeds as if the frame had completed: IDLE and release if last_q, otherwise HOLD.
- Undefined: WAIT_START waits forever. The WDOG_ERR port and counter are absent.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, SEND, WAIT_START, WAIT_END, HOLD), default N_REQ, byte width 8, WDOG counter width.
- Sub-module rr_pick: combinational round-robin picker. Inputs: request vector and PTR. Outputs: one-hot winner, winner index, any-valid. Instantiated once.

Test Plan:
- Single requester 0, byte 0xA5 with LAST -> READY[0] pulses, UART_DV one cycle later, UART_BYTE=0xA5 stable until ACTIVE falls, GRANT returns 0, PTR=1.
- Requesters 1 and 3 both valid with PTR=0 -> 1 wins and sends a 3-byte packet 0x11,0x22,0x33 (LAST on 0x33). READY[3] stays 0 throughout. Requester 3 is granted next.
- All four requesters with continuous single-byte packets -> grant order 0,1,2,3,0 with no starvation.
- Owner drops VALID for 50 cycles mid-packet -> GRANT held, BUSY=1, no DV, other requesters are not served.
- Assert RST_N=0 during WAIT_END with UART_ACTIVE still high -> outputs take reset values immediately. No arbitration until ACTIVE=0.
- With UART_ARB_WDOG_EN, hold UART_ACTIVE=0 after DV -> WDOG_ERR=1 after 16 cycles, FSM releases (LAST byte), next requester is served.
